// File: rtl/pb_debouncer_multi_if.sv
// Button pins in, conditioned per-channel levels and pulses out.
// The master drives the raw pins and the slave drives the conditioned outputs.
interface pb_debouncer_multi_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] pb_in;
  logic [CHANNELS-1:0] pb_state;
  logic [CHANNELS-1:0] pb_down;
  logic [CHANNELS-1:0] pb_up;
  logic [CHANNELS-1:0] pb_long;
  logic [CHANNELS-1:0] pb_rpt;

  modport master (
    output pb_in,
    input  pb_state, pb_down, pb_up, pb_long, pb_rpt
  );

  modport slave (
    input  pb_in,
    output pb_state, pb_down, pb_up, pb_long, pb_rpt
  );
endinterface

// File: rtl/pb_debouncer_multi.sv
// Multi-channel button conditioner: 2-FF sync, debounce, press/release/long/repeat pulses.
// pb_state follows the pin DEBOUNCE_CYCLES+1 edges after it settles; there is no backpressure.
module pb_debouncer_multi #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 131072,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter bit ACTIVE_LOW      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pb_debouncer_multi_if.slave   bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam int RW = $clog2(REPEAT_CYCLES + 1) + 1;

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_CYCLES);
  localparam logic [RW-1:0] RPT_LAST  = RW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam bit            RPT_EN    = (REPEAT_CYCLES > 0);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic          pin;
    logic          s0;
    logic          s1;
    logic          state;
    logic          down;
    logic          up;
    logic          lng;
    logic          rpt;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;
    logic [RW-1:0] rpt_cnt;
    logic          toggle;
    logic          rise;
    logic          fall;
    logic          held;
    logic          hold_hit;
    logic          rpt_hit;

    assign pin      = ACTIVE_LOW ? ~bus.pb_in[i] : bus.pb_in[i];
    assign toggle   = (s1 != state) && (db_cnt == DB_LAST);
    assign rise     = toggle && !state;
    assign fall     = toggle && state;
    assign held     = (hold_cnt == HOLD_SAT);
    // A release on the same edge as a scheduled long/repeat pulse cancels that pulse.
    assign hold_hit = state && !fall && (hold_cnt == HOLD_LAST);
    assign rpt_hit  = RPT_EN && state && !fall && held && (rpt_cnt == RPT_LAST);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s0       <= 1'b0;
        s1       <= 1'b0;
        state    <= 1'b0;
        db_cnt   <= '0;
        hold_cnt <= '0;
        rpt_cnt  <= '0;
        down     <= 1'b0;
        up       <= 1'b0;
        lng      <= 1'b0;
        rpt      <= 1'b0;
      end else begin
        s0 <= pin;
        s1 <= s0;

        if (s1 == state) begin
          db_cnt <= '0;
        end else if (toggle) begin
          state  <= ~state;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end

        down <= rise;
        up   <= fall;
        lng  <= hold_hit;
        rpt  <= rise | hold_hit | rpt_hit;

        // Hold counter saturates once the long-press threshold is reached;
        // the repeat counter only runs after that and wraps each period.
        if (!state || fall) begin
          hold_cnt <= '0;
          rpt_cnt  <= '0;
        end else begin
          if (!held) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
          if (hold_hit || rpt_hit) begin
            rpt_cnt <= '0;
          end else if (held && RPT_EN) begin
            rpt_cnt <= rpt_cnt + RW'(1);
          end
        end
      end
    end

    assign bus.pb_state[i] = state;
    assign bus.pb_down[i]  = down;
    assign bus.pb_up[i]    = up;
    assign bus.pb_long[i]  = lng;
    assign bus.pb_rpt[i]   = rpt;
  end

endmodule

// File: tb/tb_pb_debouncer_multi.sv
// Directed bench for pb_debouncer_multi: DEBOUNCE=4, HOLD=10, REPEAT=3 (dut_a) and REPEAT=0 (dut_b).
// Outputs are sampled 1 ns after each rising edge; pins change at that same point.
module tb_pb_debouncer_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] pins;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  pb_debouncer_multi_if #(.CHANNELS(2)) if_a ();
  pb_debouncer_multi_if #(.CHANNELS(2)) if_b ();

  assign if_a.pb_in = pins;
  assign if_b.pb_in = pins;

  pb_debouncer_multi #(
    .CHANNELS(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .ACTIVE_LOW(1)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a)
  );

  pb_debouncer_multi #(
    .CHANNELS(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(0), .ACTIVE_LOW(1)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [1:0] st, input logic [1:0] dn,
                         input logic [1:0] up, input logic [1:0] lg, input logic [1:0] rp);
    check({tag, "_state"}, {30'd0, if_a.pb_state}, {30'd0, st});
    check({tag, "_down"},  {30'd0, if_a.pb_down},  {30'd0, dn});
    check({tag, "_up"},    {30'd0, if_a.pb_up},    {30'd0, up});
    check({tag, "_long"},  {30'd0, if_a.pb_long},  {30'd0, lg});
    check({tag, "_rpt"},   {30'd0, if_a.pb_rpt},   {30'd0, rp});
  endtask

  initial begin
    logic [1:0] e_st;
    logic [1:0] e_up;
    logic [1:0] e_lg;
    logic [1:0] e_ra;
    logic [1:0] e_rb;

    pins  = 2'b11;
    rst_n = 1'b0;
    tick(3);
    check_a("reset", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    check("reset_b_state", {30'd0, if_b.pb_state}, 32'd0);
    rst_n = 1'b1;
    tick(5);
    check_a("idle", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    // Clean press on channel 0: state rises on the 6th edge after the pin change.
    pins[0] = 1'b0;
    tick(5);
    check_a("press_pre", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tick(1);
    check_a("press_t", 2'b01, 2'b01, 2'b00, 2'b00, 2'b01);
    check("press_t_b_rpt", {30'd0, if_b.pb_rpt}, 32'd1);

    // Long hold, then release after t+20 so state falls at t+26.
    for (int j = 1; j <= 27; j++) begin
      tick(1);
      e_st = (j < 26) ? 2'b01 : 2'b00;
      e_up = {1'b0, j == 26};
      e_lg = {1'b0, j == 10};
      e_ra = {1'b0, (j == 10) || (j > 10 && j < 26 && (j - 10) % 3 == 0)};
      e_rb = {1'b0, j == 10};
      check_a($sformatf("hold_%0d", j), e_st, 2'b00, e_up, e_lg, e_ra);
      check($sformatf("hold_b_rpt_%0d", j), {30'd0, if_b.pb_rpt}, {30'd0, e_rb});
      check($sformatf("hold_b_long_%0d", j), {30'd0, if_b.pb_long}, {30'd0, e_lg});
      if (j == 20) pins[0] = 1'b1;
    end

    // Bounce: runs of 3 cycles never reach the 4-cycle threshold.
    tick(3);
    for (int i = 0; i < 5; i++) begin
      pins[0] = (i % 2 == 1);
      tick(3);
      check_a($sformatf("bounce_%0d", i), 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    end
    tick(2);
    check_a("bounce_settle", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tick(1);
    check_a("bounce_down", 2'b01, 2'b01, 2'b00, 2'b00, 2'b01);

    // Race: release lands exactly on the long-press edge t+10.
    for (int j = 1; j <= 4; j++) begin
      tick(1);
      check($sformatf("race_down_once_%0d", j), {30'd0, if_a.pb_down}, 32'd0);
    end
    pins[0] = 1'b1;
    tick(5);
    check_a("race_pre", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    tick(1);
    check_a("race_fall", 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    check("race_b_long", {30'd0, if_b.pb_long}, 32'd0);
    check("race_b_rpt", {30'd0, if_b.pb_rpt}, 32'd0);

    // Both channels pressed together.
    tick(4);
    pins = 2'b00;
    tick(5);
    check_a("dual_pre", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tick(1);
    check_a("dual_down", 2'b11, 2'b11, 2'b00, 2'b00, 2'b11);
    tick(9);
    check_a("dual_pre_long", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    tick(1);
    check_a("dual_long", 2'b11, 2'b00, 2'b00, 2'b11, 2'b11);
    check("dual_b_long", {30'd0, if_b.pb_long}, 32'd3);
    // Release lands on t+16, which is also a repeat slot.
    pins = 2'b11;
    tick(6);
    check_a("dual_up", 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);

    // Reset mid-hold with the pin still pressed.
    tick(3);
    pins[0] = 1'b0;
    tick(6);
    check_a("rst_press", 2'b01, 2'b01, 2'b00, 2'b00, 2'b01);
    tick(4);
    rst_n = 1'b0;
    tick(1);
    check_a("rst_clear", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    check("rst_clear_b_state", {30'd0, if_b.pb_state}, 32'd0);
    rst_n = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      tick(1);
      check_a($sformatf("rst_wait_%0d", j), 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    end
    tick(1);
    check_a("rst_redown", 2'b01, 2'b01, 2'b00, 2'b00, 2'b01);
    tick(9);
    check_a("rst_prelong", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    tick(1);
    check_a("rst_long", 2'b01, 2'b00, 2'b00, 2'b01, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pb_debouncer_multi.md
Name: pb_debouncer_multi

Overview:
Parametrised multi-channel push-button conditioner for the board's button inputs. Each channel synchronises an asynchronous, glitchy button pin into the clk domain and debounces it with a consecutive-mismatch counter. Each channel produces a level state, one-cycle press/release pulses, a one-shot long-press pulse and a typematic auto-repeat pulse stream. It feeds the game/robot control logic directly.

Parameters:
CHANNELS, 4, number of independent button channels (>=1)
DEBOUNCE_CYCLES, 131072, consecutive clocks of disagreement required before a state change (>=1)
HOLD_CYCLES, 25000000, clocks of continuous press before long-press and first repeat (>=2)
REPEAT_CYCLES, 5000000, auto-repeat period after the first repeat; 0 disables further repeats
ACTIVE_LOW, 1, 1: pin low = pressed; 0: pin high = pressed

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous reset, active-low
pb_in  input  CHANNELS  raw asynchronous button pins; bit i = channel i
pb_state  output  CHANNELS  debounced level, 1 = pressed
pb_down  output  CHANNELS  1-cycle pulse on debounced press
pb_up  output  CHANNELS  1-cycle pulse on debounced release
pb_long  output  CHANNELS  1-cycle pulse, once per press, after HOLD_CYCLES held
pb_rpt  output  CHANNELS  1-cycle typematic pulses while held

Behaviour:
- Reset: sampled only on a rising edge with rst_n=0. Clears every synchroniser FF, debounce counter, hold/repeat counter and all outputs to 0 (released). No output pulses on the reset edge.
- Polarity: each pin is inverted before the first synchroniser FF when ACTIVE_LOW=1. Internal logic is active-high.
- Synchroniser: 2 FFs per channel (s0 <= pin, s1 <= s0).
- Debounce, per channel, counter width = clog2(DEBOUNCE_CYCLES)+1:
  - s1 == pb_state: counter <= 0.
  - Otherwise: counter increments; on the edge where counter == DEBOUNCE_CYCLES-1, pb_state toggles and counter <= 0.
  - Any single agreeing cycle restarts the count.
- Latency: pin settles before edge k → pb_state changes at edge k+DEBOUNCE_CYCLES+1, i.e. the (DEBOUNCE_CYCLES+2)th edge counting k as the first.
- Pulses are registered and update on the same edge as pb_state:
  - pb_down = 1 for exactly the cycle after the 0→1 edge.
  - pb_up = 1 for exactly the cycle after the 1→0 edge.
- Hold/repeat, per channel. Let t = the edge that raises pb_state.
  - pb_rpt pulses at t (coincident with pb_down), at t+HOLD_CYCLES, then at t+HOLD_CYCLES+n*REPEAT_CYCLES for n>=1 (only if REPEAT_CYCLES>0), for as long as pressed.
  - pb_long pulses once, at t+HOLD_CYCLES.
  - Counters must not overflow on indefinitely long holds. The hold counter saturates after the threshold; the repeat counter wraps at REPEAT_CYCLES.
- Release: on the edge pb_state falls, hold/repeat counters clear. A pb_long/pb_rpt pulse scheduled for that same edge is suppressed (release wins). No pb_long/pb_rpt pulse ever occurs while pb_state=0.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses on the corresponding bits.
- Reset mid-operation aborts any debounce/hold in progress. If a button is still pressed when rst_n returns high, it is re-detected as a fresh press: pb_down after the full sync+debounce latency, never immediately.
- pb_down and pb_up are never both 1 on one channel in one cycle. pb_long implies pb_rpt in the same cycle.

Test Plan:
Bench parameters: CHANNELS=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, ACTIVE_LOW=1.
1. Clean press: pb_in[0] 1→0 before edge k, held → pb_state[0]=1 and pb_down[0]=1 after edge k+5; pb_down[0] low after k+6. Channel 1 outputs stay 0 throughout.
2. Bounce: pb_in[0] toggles with runs of 3 cycles, 5 times, then stays 0 → no pb_state/pb_down change during bouncing. pb_down[0] occurs DEBOUNCE_CYCLES+2 edges after the final transition, exactly once.
3. Release: from pressed, pb_in[0] 0→1 held → pb_up[0] single pulse 6 edges later, pb_state[0]=0, no pb_down/pb_rpt.
4. Long hold: press, pb_down at edge t, hold 20 more cycles → pb_rpt[0] at t, t+10, t+13, t+16, t+19. pb_long[0] only at t+10. Rerun with REPEAT_CYCLES=0 → pb_rpt only at t and t+10.
5. Race: release timed so pb_state falls exactly at t+10 → no pb_long, no pb_rpt at t+10, pb_up asserted. Both channels pressed on the same edge → identical pulse timing on bits 0 and 1.
6. Reset: rst_n=0 for 1 edge at t+5 of a hold with pb_in[0] still 0 → all outputs 0 next cycle. After rst_n=1, pb_down[0] reappears after 6 edges, then pb_long at 10 edges beyond that.
